// File: rtl/kernel_bc_write_back_burst.sv
// -----------------------------------------------------------------------------
// kernel_bc_write_back_burst
//
// Write-back stage of the kernel_bc dataflow region. Pops one start token per
// invocation, latches the destination base address and word count, then drains
// BC score words from the result FIFO and writes them to memory as AXI-style
// write bursts of at most BURST_LEN beats, with at most MAX_OUTSTANDING bursts
// awaiting a write response. Completion is signalled with ap_done/ap_continue.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start_empty_n/_read/_dout  start-token FIFO (token value is ignored)
//   base_addr, num_words       job parameters, sampled on the token pop
//   data_empty_n/_read/_dout   result FIFO (first-word-fall-through)
//   m_aw*                      write-address channel (registered outputs)
//   m_w*                       write-data channel (combinational from FIFO)
//   m_bvalid/m_bready          write-response channel
//   ap_continue/done/idle/ready  block-level handshake
// -----------------------------------------------------------------------------
module kernel_bc_write_back_burst #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 32,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // start-token FIFO
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic                  start_dout,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  // result FIFO
  input  logic                  data_empty_n,
  output logic                  data_read,
  input  logic [DATA_WIDTH-1:0] data_dout,
  // write-address channel
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  // write-data channel
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  // write-response channel
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // block-level handshake
  input  logic                  ap_continue,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state_q,       state_d;
  logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q,   remaining_d;
  logic [8:0]            beats_q,       beats_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  awvalid_q,     awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,      awaddr_d;
  logic [7:0]            awlen_q,       awlen_d;

  logic       aw_hs;
  logic       b_hs;
  logic [8:0] burst_words;
  logic [8:0] next_len;

  // The token value carries no information for this stage.
  logic unused_start_dout;
  assign unused_start_dout = start_dout;

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  assign ap_idle  = (state_q == S_IDLE);
  assign ap_done  = (state_q == S_DONE);
  assign ap_ready = ap_done;

  // A token popped while reset is asserted would be silently lost.
  assign start_read = ap_idle & start_empty_n & ~reset;

  assign m_wvalid  = (state_q == S_DATA) & data_empty_n;
  assign m_wdata   = (state_q == S_DATA) ? data_dout : '0;
  assign m_wlast   = (state_q == S_DATA) && (beats_q == 9'd1);
  assign data_read = m_wvalid & m_wready;
  assign m_bready  = (state_q != S_IDLE);

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;

  assign aw_hs       = awvalid_q & m_awready;
  assign b_hs        = m_bvalid & m_bready;
  assign burst_words = {1'b0, awlen_q} + 9'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    beats_d       = beats_q;
    outstanding_d = outstanding_q;

    // An AW and a B in the same cycle cancel; a stray B never underflows.
    unique case ({aw_hs, b_hs})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_read) begin
          addr_d      = base_addr;
          remaining_d = num_words;
          state_d     = (num_words == '0) ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          beats_d     = burst_words;
          addr_d      = addr_q + ADDR_WIDTH'(burst_words) * ADDR_WIDTH'(BYTES_PER_WORD);
          remaining_d = remaining_q - CNT_WIDTH'(burst_words);
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (data_read) begin
          beats_d = beats_q - 9'd1;
          if (beats_q == 9'd1) state_d = (remaining_q != '0) ? S_ADDR : S_RESP;
        end
      end
      S_RESP: begin
        // Looking at the next count lets ap_done follow the final B by one cycle.
        if (outstanding_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // AW channel is registered: prepare the request for the state being entered.
    // Once valid it stays valid, since the outstanding count cannot grow in ADDR.
    next_len  = (remaining_d >= CNT_WIDTH'(BURST_LEN)) ? 9'(BURST_LEN) : 9'(remaining_d);
    awvalid_d = (state_d == S_ADDR) && (outstanding_d < OUT_W'(MAX_OUTSTANDING));
    awaddr_d  = (state_d == S_ADDR) ? addr_d : '0;
    awlen_d   = (state_d == S_ADDR) ? 8'(next_len - 9'd1) : 8'd0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values,
    // independent of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      outstanding_q <= '0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      beats_q       <= beats_d;
      outstanding_q <= outstanding_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
    end
  end

endmodule

// File: tb/tb_kernel_bc_write_back_burst.sv
// -----------------------------------------------------------------------------
// Testbench for kernel_bc_write_back_burst.
// A background process plays the start FIFO, the result FIFO and a memory
// slave with adjustable readiness, logging every AW and W handshake. Each test
// task builds the expected burst list and data stream from the job parameters
// and compares the logs and handshake timing against them.
// -----------------------------------------------------------------------------
module tb_kernel_bc_write_back_burst;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam int BL = 16;
  localparam int MO = 4;

  logic          clk;
  logic          reset;
  logic          start_empty_n, start_read, start_dout;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic          data_empty_n, data_read;
  logic [DW-1:0] data_dout;
  logic          m_awvalid, m_awready;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_wvalid, m_wready, m_wlast;
  logic [DW-1:0] m_wdata;
  logic          m_bvalid, m_bready;
  logic          ap_continue, ap_done, ap_idle, ap_ready;

  kernel_bc_write_back_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
    .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .start_empty_n(start_empty_n), .start_read(start_read), .start_dout(start_dout),
    .base_addr(base_addr), .num_words(num_words),
    .data_empty_n(data_empty_n), .data_read(data_read), .data_dout(data_dout),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .ap_continue(ap_continue), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Environment state shared between the slave process and the tests.
  logic [31:0] fifo_q[$];
  logic [31:0] tok_base[$];
  logic [31:0] tok_num[$];
  logic [39:0] aw_log[$];
  logic [31:0] w_log[$];
  bit          wlast_log[$];
  int b_pending = 0, b_count = 0, b_credit = 0;
  bit hold_b = 0;
  int aw_pct = 100, w_pct = 100, e_pct = 100, b_pct = 100;
  int pop_cyc = -1, first_awv_cyc = -1, last_b_cyc = -1, first_done_cyc = -1;

  // Expected results from the reference model.
  logic [39:0] exp_aw[$];
  logic [31:0] exp_w[$];
  bit          exp_last[$];

  // Slave / FIFO process: drive inputs on the falling edge, then log what will
  // be accepted on the coming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      m_awready     = ($urandom_range(99) < aw_pct);
      m_wready      = ($urandom_range(99) < w_pct);
      data_empty_n  = (fifo_q.size() > 0) && ($urandom_range(99) < e_pct);
      data_dout     = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
      m_bvalid      = (b_pending > 0) && (!hold_b || b_credit > 0) && ($urandom_range(99) < b_pct);
      start_empty_n = (tok_base.size() > 0);
      base_addr     = (tok_base.size() > 0) ? tok_base[0] : $urandom;
      num_words     = (tok_num.size() > 0) ? tok_num[0] : $urandom;
      start_dout    = 1'($urandom);
      #1;
      if (reset) continue;
      checks++;
      if (data_read !== (m_wvalid & m_wready)) begin
        errors++;
        $display("FAIL data_read_vs_w_handshake cyc=%0d got=%b want=%b", cyc, data_read, m_wvalid & m_wready);
      end
      if (start_read) begin
        void'(tok_base.pop_front());
        void'(tok_num.pop_front());
        pop_cyc = cyc;
      end
      if (m_awvalid && first_awv_cyc < 0) first_awv_cyc = cyc;
      if (m_awvalid && m_awready) aw_log.push_back({m_awaddr, m_awlen});
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata);
        wlast_log.push_back(m_wlast);
        if (m_wlast) b_pending++;
      end
      if (data_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (m_bvalid && m_bready) begin
        b_pending--;
        b_count++;
        last_b_cyc = cyc;
        if (hold_b) b_credit--;
      end
      if (ap_done && first_done_cyc < 0) first_done_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Advance to the sample point of the next cycle (after the slave has logged).
  task automatic wait_cycle();
    @(negedge clk);
    #2;
  endtask

  // Reference model: bursts are carved greedily from the word count, each at
  // most BL beats, addresses advancing by the bytes written.
  task automatic start_job(input logic [31:0] base, input int n);
    logic [31:0] a;
    int r, len;
    aw_log.delete(); w_log.delete(); wlast_log.delete();
    exp_aw.delete(); exp_w.delete(); exp_last.delete();
    b_count = 0; pop_cyc = -1; first_awv_cyc = -1; last_b_cyc = -1; first_done_cyc = -1;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back($urandom);
      fifo_q.push_back(exp_w[i]);
    end
    a = base;
    r = n;
    while (r > 0) begin
      len = (r < BL) ? r : BL;
      exp_aw.push_back({a, 8'(len - 1)});
      for (int k = 0; k < len; k++) exp_last.push_back(k == len - 1);
      a = a + 32'(len * (DW / 8));
      r = r - len;
    end
    tok_base.push_back(base);
    tok_num.push_back(32'(n));
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && ap_done !== 1'b1; i++) wait_cycle();
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout got ap_done=%b want 1 within %0d cycles", name, ap_done, budget);
    end
  endtask

  task automatic release_done();
    ap_continue = 1'b1;
    wait_cycle();
    ap_continue = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [80:0] got;
    reset = 1'b1;
    repeat (3) wait_cycle();
    got = {ap_idle, ap_done, ap_ready, start_read, m_awvalid, m_wvalid, m_wlast,
           data_read, m_bready, m_awaddr, m_awlen, m_wdata};
    checks++;
    if (got !== {9'h100, 72'h0}) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=%h", got, {9'h100, 72'h0});
    end
    reset = 1'b0;
    wait_cycle();
  endtask

  task automatic test_single_burst();
    start_job(32'h1000, 16);
    wait_done("single", 200);
    checks++;
    if (aw_log.size() != 1 || aw_log[0] !== {32'h1000, 8'd15}) begin
      errors++;
      $display("FAIL single_aw got n=%0d first=%h want n=1 first=%h", aw_log.size(),
               (aw_log.size() > 0) ? aw_log[0] : 40'h0, {32'h1000, 8'd15});
    end
    checks++;
    if (w_log.size() != 16) begin
      errors++;
      $display("FAIL single_beats got=%0d want=16", w_log.size());
    end
    foreach (exp_w[i]) if (i < w_log.size()) begin
      checks++;
      if (w_log[i] !== exp_w[i] || wlast_log[i] !== (i == 15)) begin
        errors++;
        $display("FAIL single_beat%0d got=%h/%b want=%h/%b", i, w_log[i], wlast_log[i], exp_w[i], i == 15);
      end
    end
    checks++;
    if (first_awv_cyc != pop_cyc + 1) begin
      errors++;
      $display("FAIL single_pop_to_awvalid got=%0d want=%0d", first_awv_cyc - pop_cyc, 1);
    end
    checks++;
    if (b_count != 1 || first_done_cyc != last_b_cyc + 1) begin
      errors++;
      $display("FAIL single_b_to_done got b=%0d lat=%0d want b=1 lat=1", b_count, first_done_cyc - last_b_cyc);
    end
    release_done();
  endtask

  task automatic test_multi_burst();
    start_job(32'h1000, 40);
    wait_done("multi", 400);
    checks++;
    if (aw_log.size() != 3) begin
      errors++;
      $display("FAIL multi_aw_count got=%0d want=3", aw_log.size());
    end
    foreach (exp_aw[i]) if (i < aw_log.size()) begin
      checks++;
      if (aw_log[i] !== exp_aw[i]) begin
        errors++;
        $display("FAIL multi_aw%0d got=%h want=%h", i, aw_log[i], exp_aw[i]);
      end
    end
    checks++;
    if (w_log.size() != 40) begin
      errors++;
      $display("FAIL multi_beats got=%0d want=40", w_log.size());
    end
    foreach (exp_w[i]) if (i < w_log.size()) begin
      checks++;
      if (w_log[i] !== exp_w[i] || wlast_log[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL multi_beat%0d got=%h/%b want=%h/%b", i, w_log[i], wlast_log[i], exp_w[i], exp_last[i]);
      end
    end
    release_done();
  endtask

  task automatic test_outstanding_limit();
    bit awv_seen;
    int i, b_at;
    hold_b = 1; b_credit = 0;
    start_job(32'h4000, 96);
    for (i = 0; i < 1000 && w_log.size() < 64; i++) wait_cycle();
    awv_seen = 0;
    repeat (10) begin
      wait_cycle();
      if (m_awvalid) awv_seen = 1;
    end
    checks++;
    if (aw_log.size() != 4 || awv_seen) begin
      errors++;
      $display("FAIL outstanding_stall got aws=%0d awvalid_seen=%b want aws=4 awvalid_seen=0", aw_log.size(), awv_seen);
    end
    b_credit = 1;
    for (i = 0; i < 20 && b_count == 0; i++) wait_cycle();
    b_at = cyc;
    checks++;
    if (b_count != 1 || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL outstanding_b_cycle got b=%0d awvalid=%b want b=1 awvalid=0", b_count, m_awvalid);
    end
    wait_cycle();
    checks++;
    if (m_awvalid !== 1'b1 || cyc != b_at + 1) begin
      errors++;
      $display("FAIL outstanding_fifth_aw got awvalid=%b want 1 one cycle after B", m_awvalid);
    end
    hold_b = 0;
    wait_done("outstanding", 1000);
    checks++;
    if (aw_log.size() != 6 || b_count != 6 || w_log.size() != 96) begin
      errors++;
      $display("FAIL outstanding_totals got aws=%0d bs=%0d beats=%0d want 6/6/96", aw_log.size(), b_count, w_log.size());
    end
    foreach (exp_aw[k]) if (k < aw_log.size()) begin
      checks++;
      if (aw_log[k] !== exp_aw[k]) begin
        errors++;
        $display("FAIL outstanding_aw%0d got=%h want=%h", k, aw_log[k], exp_aw[k]);
      end
    end
    foreach (exp_w[k]) if (k < w_log.size()) begin
      checks++;
      if (w_log[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL outstanding_beat%0d got=%h want=%h", k, w_log[k], exp_w[k]);
      end
    end
    release_done();
  endtask

  task automatic test_back_pressure();
    for (int it = 0; it < 5; it++) begin
      int n;
      aw_pct = $urandom_range(30, 90);
      w_pct  = $urandom_range(30, 90);
      e_pct  = $urandom_range(30, 90);
      b_pct  = $urandom_range(30, 90);
      n = $urandom_range(1, 70);
      start_job(32'h10000 + {$urandom_range(0, 255), 6'b0}, n);
      wait_done("backpressure", 5000);
      checks++;
      if (b_pending != 0 || b_count != exp_aw.size() || aw_log.size() != exp_aw.size()
          || w_log.size() != n) begin
        errors++;
        $display("FAIL bp%0d_totals got bpend=%0d bs=%0d aws=%0d beats=%0d want 0/%0d/%0d/%0d",
                 it, b_pending, b_count, aw_log.size(), w_log.size(), exp_aw.size(), exp_aw.size(), n);
      end
      foreach (exp_aw[i]) if (i < aw_log.size()) begin
        checks++;
        if (aw_log[i] !== exp_aw[i]) begin
          errors++;
          $display("FAIL bp%0d_aw%0d got=%h want=%h", it, i, aw_log[i], exp_aw[i]);
        end
      end
      foreach (exp_w[i]) if (i < w_log.size()) begin
        checks++;
        if (w_log[i] !== exp_w[i] || wlast_log[i] !== exp_last[i]) begin
          errors++;
          $display("FAIL bp%0d_beat%0d got=%h/%b want=%h/%b", it, i, w_log[i], wlast_log[i], exp_w[i], exp_last[i]);
        end
      end
      release_done();
    end
    aw_pct = 100; w_pct = 100; e_pct = 100; b_pct = 100;
  endtask

  task automatic test_zero_count();
    bit dropped;
    start_job(32'h5000, 0);
    wait_done("zero", 50);
    checks++;
    if (first_done_cyc != pop_cyc + 2 || aw_log.size() != 0 || w_log.size() != 0) begin
      errors++;
      $display("FAIL zero_timing got lat=%0d aws=%0d beats=%0d want lat=2 aws=0 beats=0",
               first_done_cyc - pop_cyc, aw_log.size(), w_log.size());
    end
    dropped = 0;
    repeat (10) begin
      wait_cycle();
      if (ap_done !== 1'b1 || ap_ready !== 1'b1 || ap_idle !== 1'b0 || m_awvalid !== 1'b0) dropped = 1;
    end
    checks++;
    if (dropped) begin
      errors++;
      $display("FAIL zero_hold got ap_done dropped or awvalid raised while ap_continue=0, want steady done");
    end
    ap_continue = 1'b1;
    wait_cycle();
    ap_continue = 1'b0;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_continue got idle=%b done=%b want idle=1 done=0", ap_idle, ap_done);
    end
    start_job(32'h6000, 5);
    wait_done("zero_second", 200);
    checks++;
    if (aw_log.size() != 1 || aw_log[0] !== {32'h6000, 8'd4} || w_log.size() != 5) begin
      errors++;
      $display("FAIL zero_second_job got aws=%0d beats=%0d want aws=1 (6000/4) beats=5", aw_log.size(), w_log.size());
    end
    release_done();
  endtask

  task automatic test_reset_mid_burst();
    logic [80:0] got;
    int i;
    start_job(32'h2000, 16);
    for (i = 0; i < 200 && w_log.size() < 5; i++) wait_cycle();
    reset = 1'b1;
    wait_cycle();
    got = {ap_idle, ap_done, ap_ready, start_read, m_awvalid, m_wvalid, m_wlast,
           data_read, m_bready, m_awaddr, m_awlen, m_wdata};
    checks++;
    if (got !== {9'h100, 72'h0}) begin
      errors++;
      $display("FAIL midreset_outputs got=%h want=%h", got, {9'h100, 72'h0});
    end
    reset = 1'b0;
    fifo_q.delete(); aw_log.delete(); w_log.delete(); wlast_log.delete();
    b_pending = 0;
    repeat (10) wait_cycle();
    checks++;
    if (aw_log.size() != 0 || w_log.size() != 0 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet got aws=%0d beats=%0d idle=%b want 0/0/1", aw_log.size(), w_log.size(), ap_idle);
    end
    start_job(32'h3000, 16);
    wait_done("midreset_fresh", 200);
    checks++;
    if (aw_log.size() != 1 || aw_log[0] !== {32'h3000, 8'd15} || w_log.size() != 16) begin
      errors++;
      $display("FAIL midreset_fresh got aws=%0d beats=%0d want aws=1 (3000/15) beats=16", aw_log.size(), w_log.size());
    end
    foreach (exp_w[k]) if (k < w_log.size()) begin
      checks++;
      if (w_log[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL midreset_beat%0d got=%h want=%h", k, w_log[k], exp_w[k]);
      end
    end
    release_done();
  endtask

  initial begin
    reset = 1'b1; ap_continue = 1'b0;
    start_empty_n = 1'b0; start_dout = 1'b0; base_addr = '0; num_words = '0;
    data_empty_n = 1'b0; data_dout = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_outstanding_limit();
    test_back_pressure();
    test_zero_count();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
